// File: rtl/hdmi_packet_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_packet_pkg
//   Shared constants, types and the BCH step function for HDMI data-island
//   packets. Imported by packet_assembler, bch_ecc_lane and packet_picker.
//
//   Contents:
//     PACKET_LEN          pixels per packet (32)
//     HEADER_BITS         header payload bits (24)
//     SUB_BITS            subpacket payload bits (56)
//     SUB_COUNT           subpackets per packet (4)
//     BCH_POLY            reflected BCH generator (8'h83)
//     subpacket_array_t   4 x 56-bit subpacket bundle
//     next_ecc()          one serial LFSR step of the BCH parity
// ---------------------------------------------------------------------------
package hdmi_packet_pkg;

    localparam int PACKET_LEN  = 32;
    localparam int HEADER_BITS = 24;
    localparam int SUB_BITS    = 56;
    localparam int SUB_COUNT   = 4;
    localparam int ECC_BITS    = 8;

    localparam logic [ECC_BITS-1:0] BCH_POLY = 8'h83;

    // Counter values where each lane switches from payload to parity.
    localparam logic [4:0] HEADER_PARITY_START = 5'd24;
    localparam logic [4:0] SUB_PARITY_START    = 5'd28;
    localparam logic [4:0] LAST_PIXEL          = 5'(PACKET_LEN - 1);

    typedef logic [SUB_COUNT-1:0][SUB_BITS-1:0] subpacket_array_t;

    // Serial BCH step: shift right, fold the polynomial back in when the
    // outgoing bit disagrees with the incoming data bit.
    function automatic logic [ECC_BITS-1:0] next_ecc(
        input logic [ECC_BITS-1:0] ecc,
        input logic                data_bit
    );
        next_ecc = {1'b0, ecc[ECC_BITS-1:1]} ^ ((ecc[0] ^ data_bit) ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/bch_ecc_lane.sv
// ---------------------------------------------------------------------------
// bch_ecc_lane
//   Accumulates the BCH parity of one packet lane, BITS_PER_CYCLE data bits
//   per advancing cycle (bit 0 is processed first).
//
//   Ports:
//     clk        pixel clock
//     reset      asynchronous, active-high reset
//     clear      use a zero seed this cycle instead of the stored parity;
//                with advance low the register is zeroed
//     advance    step the LFSR with data_bits; when low (and clear low)
//                the parity holds
//     data_bits  payload bits for this cycle
//     ecc        current accumulated parity
// ---------------------------------------------------------------------------
module bch_ecc_lane
    import hdmi_packet_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      advance,
    input  logic [BITS_PER_CYCLE-1:0] data_bits,
    output logic [ECC_BITS-1:0]       ecc
);

    logic [ECC_BITS-1:0] r_ecc;
    logic [ECC_BITS-1:0] w_stepped;

    // NOTE: blocking assignments here chain the steps within one cycle; the
    // register below uses non-blocking so all lanes update together.
    always_comb begin
        w_stepped = clear ? '0 : r_ecc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_stepped = next_ecc(w_stepped, data_bits[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ecc <= '0;
        end else if (advance) begin
            r_ecc <= w_stepped;
        end else if (clear) begin
            r_ecc <= '0;
        end
    end

    assign ecc = r_ecc;

endmodule

// File: rtl/packet_assembler.sv
// ---------------------------------------------------------------------------
// packet_assembler
//   Serialises one 32-pixel HDMI data-island packet per period: header lane
//   on bit 0, subpacket even/odd bits on [4:1]/[8:5], each lane followed by
//   its BCH parity (LSB first). Output is registered one pixel behind the
//   counter.
//
//   Ports:
//     clk_pixel             pixel clock
//     reset                 asynchronous, active-high reset
//     data_island_next      one cycle before data_island_period first rises
//     data_island_period    high for every data-island pixel
//     header                HB2:HB1:HB0 from packet_picker
//     sub                   subpackets 0..3 from packet_picker
//     packet_enable         picker may select the next packet (combinational)
//     packet_pixel_counter  position within the current packet
//     packet_data           9-bit data-island word for the TERC4 encoders
// ---------------------------------------------------------------------------
module packet_assembler
    import hdmi_packet_pkg::*;
(
    input  logic                                  clk_pixel,
    input  logic                                  reset,
    input  logic                                  data_island_next,
    input  logic                                  data_island_period,
    input  logic [HEADER_BITS-1:0]                header,
    input  logic [SUB_COUNT-1:0][SUB_BITS-1:0]    sub,
    output logic                                  packet_enable,
    output logic [4:0]                            packet_pixel_counter,
    output logic [8:0]                            packet_data
);

    logic [4:0]             r_counter;
    logic [HEADER_BITS-1:0] r_header;
    subpacket_array_t       r_sub;
    logic [8:0]             r_packet_data;

    logic                   w_first;
    logic                   w_header_payload;
    logic                   w_sub_payload;
    logic                   w_ecc_clear;
    logic [HEADER_BITS-1:0] w_header;
    subpacket_array_t       w_sub;
    logic [8:0]             w_data;

    // Payload widened to a power of two so the counter can index it over its
    // full range; the padding is never selected.
    logic [31:0]                  w_header_ext;
    logic [SUB_COUNT-1:0][63:0]   w_sub_ext;

    logic [ECC_BITS-1:0]                 w_header_ecc;
    logic [SUB_COUNT-1:0][ECC_BITS-1:0]  w_sub_ecc;

    assign w_first          = (r_counter == 5'd0);
    assign w_header_payload = (r_counter < HEADER_PARITY_START);
    assign w_sub_payload    = (r_counter < SUB_PARITY_START);

    // Pixel 0 uses the picker's outputs directly; the hold registers take
    // over for the rest of the packet so the picker is free to move on.
    assign w_header     = w_first ? header : r_header;
    assign w_sub        = w_first ? sub    : r_sub;
    assign w_header_ext = {8'h00, w_header};

    // Zero seed at the start of every packet and while idle or aborted.
    assign w_ecc_clear = !data_island_period || w_first;

    bch_ecc_lane #(
        .BITS_PER_CYCLE (1)
    ) u_header_ecc (
        .clk       (clk_pixel),
        .reset     (reset),
        .clear     (w_ecc_clear),
        .advance   (data_island_period && w_header_payload),
        .data_bits (w_header_ext[r_counter]),
        .ecc       (w_header_ecc)
    );

    for (genvar i = 0; i < SUB_COUNT; i++) begin : g_sub_lane
        assign w_sub_ext[i] = {8'h00, w_sub[i]};

        bch_ecc_lane #(
            .BITS_PER_CYCLE (2)
        ) u_sub_ecc (
            .clk       (clk_pixel),
            .reset     (reset),
            .clear     (w_ecc_clear),
            .advance   (data_island_period && w_sub_payload),
            .data_bits ({w_sub_ext[i][{r_counter, 1'b1}], w_sub_ext[i][{r_counter, 1'b0}]}),
            .ecc       (w_sub_ecc[i])
        );
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a bit unassigned and infer a latch.
    always_comb begin
        w_data = '0;
        // Parity phase indexes: header k-24 is counter[2:0], sub k-28 is
        // counter[1:0] (two bits per pixel).
        w_data[0] = w_header_payload ? w_header_ext[r_counter]
                                     : w_header_ecc[r_counter[2:0]];
        for (int i = 0; i < SUB_COUNT; i++) begin
            w_data[1 + i] = w_sub_payload ? w_sub_ext[i][{r_counter, 1'b0}]
                                          : w_sub_ecc[i][{r_counter[1:0], 1'b0}];
            w_data[5 + i] = w_sub_payload ? w_sub_ext[i][{r_counter, 1'b1}]
                                          : w_sub_ecc[i][{r_counter[1:0], 1'b1}];
        end
    end

    // NOTE: the header/subpacket hold registers are reset too, so a packet
    // started straight after reset never serialises stale contents.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_counter     <= '0;
            r_header      <= '0;
            r_sub         <= '0;
            r_packet_data <= '0;
        end else if (data_island_period) begin
            r_counter     <= r_counter + 5'd1;
            r_packet_data <= w_data;
            if (w_first) begin
                r_header <= header;
                r_sub    <= sub;
            end
        end else begin
            // Idle or aborted: nothing partial ever reaches the encoders.
            r_counter     <= '0;
            r_packet_data <= '0;
        end
    end

    // Period takes precedence over the early warning, so an overlapping
    // data_island_next only matters when the period is low.
    assign packet_enable = (data_island_next && !data_island_period)
                         || (data_island_period && (r_counter == LAST_PIXEL));

    assign packet_pixel_counter = r_counter;
    assign packet_data          = r_packet_data;

endmodule

// File: doc/packet_assembler.md
# packet_assembler

Serialises the packet selected by `packet_picker` into the 9-bit-per-pixel data-island stream that feeds the TMDS channel encoders. It computes the BCH ECC parity for the header and the four subpackets, and drives the 32-cycle packet counter. It also tells the picker when to select the next packet, and sits between `packet_picker` (upstream) and the TERC4 encoders (downstream).

## Interface
- `PACKET_LEN`, 32: pixels per packet (fixed; not overridable in practice).
- `clk_pixel`  in  1  pixel clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `data_island_next`  in  1  high exactly one cycle before `data_island_period` first rises.
- `data_island_period`  in  1  high for every data-island pixel (whole multiples of 32).
- `header`  in  24  packet header HB2:HB1:HB0 from picker.
- `sub`  in  4×56  subpackets 0..3 from picker.
- `packet_enable`  out  1  picker may select the next packet type (combinational).
- `packet_pixel_counter`  out  5  position within the current packet.
- `packet_data`  out  9  bit0 = header/BCH bit; bits[4:1] = even bits of sub0..3; bits[8:5] = odd bits of sub0..3.

## Operation
- `packet_pixel_counter` behaviour:
  - Resets to 0.
  - Increments modulo 32 while `data_island_period` is high.
  - Forced to 0 on any cycle where `data_island_period` is low.
- `packet_enable` = (`data_island_next` && !`data_island_period`) || (`data_island_period` && counter==31). The picker therefore updates `packet_type` on the edge entering counter 0.
- Capture:
  - At counter 0, `header` and `sub` are used live and loaded into hold registers.
  - At counters 1..31, the hold registers are used.
- Per cycle at counter k, output selection (registered, see Timing):
  - Header: k<24 sends header bit k; k≥24 sends header_ecc bit (k−24).
  - Sub i: k<28 sends bits 2k and 2k+1; k≥28 sends sub_ecc[i] bits 2(k−28) and 2(k−28)+1.
- ECC uses the serial LFSR: next = (ecc>>1) ^ ((ecc[0]^bit) ? 8'h83 : 0).
  - Header lane: one step per cycle for k<24.
  - Sub lanes: two steps per cycle (even bit first) for k<28.
  - The ECC seed is 0 at k=0 (the accumulator register is ignored at k=0).
  - ECC registers hold during the parity phase.
  - Parity is sent LSB first.
- Abort: if `data_island_period` falls mid-packet, the counter and all ECC registers clear, and the next `packet_data` is 0. No partial parity is emitted.
- Reset values: `packet_data`=0, counter=0, ECC=0, hold registers=0, `packet_enable`=0 (inputs low).

## Timing
- Latency: `packet_data` is registered, one cycle after the counter value it encodes. Cycle k data appears while the counter shows k+1 (or 0 after wrap/abort).
- The downstream guard-band/TERC4 logic compensates for this one-cycle offset; it is fixed.
- Back-to-back packets: counter 31→0 with no gap. The new packet's bit 0 follows the previous parity bit 7 on consecutive cycles.
- Asynchronous reset mid-packet: all state clears immediately. The first packet after release starts only on a new `data_island_next` or a counter-0 entry.
- `data_island_next` and `data_island_period` both high: `data_island_period` takes precedence; `packet_enable` follows the counter==31 rule only.

## Structure
- Package `hdmi_packet_pkg` contains:
  - `BCH_POLY` = 8'h83, `PACKET_LEN`, `HEADER_BITS`=24, `SUB_BITS`=56.
  - Function `next_ecc(ecc, bit)`.
  - A typedef for the 4×56 subpacket array, shared with `packet_picker`.
- Sub-module `bch_ecc_lane`:
  - Parameter `BITS_PER_CYCLE` (1 or 2).
  - Ports: clk/reset, `clear`, `advance`, `data_bits`; outputs `ecc[7:0]`.
  - Instantiated once for the header and four times for the subpackets.

## Test plan
- Null packet: header=0, sub=0 for one packet → `packet_data`=9'h000 on all 32 output cycles.
- Header 24'h000001, subs 0 → bit0 pattern is 1 at cycle 0, then 0 for cycles 1–23. Parity 0x4A appears LSB first on cycles 24–31 (0,1,0,1,0,0,1,0).
- Sub bit mapping:
  - sub[0]=56'h1 → `packet_data`[1] high at cycle 0.
  - sub[0]=56'h2 → `packet_data`[5] high at cycle 0.
  - sub[3]=56'h1 → `packet_data`[4]; in each case, non-zero parity follows on cycles 28–31, matching the golden model.
- Handshake: `data_island_next` pulse, then 64 cycles of `data_island_period` → `packet_enable` high on the pre-cycle and at counter 31 (twice total). The captured header changes only at counter 0.
- Abort: drop `data_island_period` at counter 10 → counter=0, next `packet_data`=0. The following island restarts with a clean ECC, and its parity matches the golden model.
- Asynchronous reset asserted at counter 20 mid-clock → outputs are 0 before the next edge. After release, the first full packet is bit-exact against the model.
